wr_out_buffer: RTL and testbench

Downstream stage of the CNN write path: consumes the 32-bit words assembled by the byte-packing write register and writes them to output memory. Holds up to DEPTH words in a small FIFO and generates sequential write addresses from BASE_ADDR. Pulses a clear back to the packer on every accepted word, and signals completion once the last word of a tile is committed to memory.

---
 rtl/wr_out_buffer_if.sv | 28 ++
 rtl/wr_out_buffer.sv | 121 ++++++++++++
 tb/tb_wr_out_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_out_buffer_if.sv
// Packer-side and memory-side handshake bundle for wr_out_buffer.
// slave is the buffer's view; master is the packer/memory view.
interface wr_out_buffer_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [31:0]       in_word;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              pack_clr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_gnt;
    logic              done;
    logic              stray;

    modport slave (
        input  start, in_word, in_valid, in_last, mem_gnt,
        output in_ready, pack_clr, mem_addr, mem_wdata, mem_we, done, stray
    );

    modport master (
        output start, in_word, in_valid, in_last, mem_gnt,
        input  in_ready, pack_clr, mem_addr, mem_wdata, mem_we, done, stray
    );
endinterface

// File: rtl/wr_out_buffer.sv
// FIFO-backed write stage between the byte packer and output memory; sequential addresses from BASE_ADDR.
// Defining WROB_STRAY_FLAG_EN builds the sticky stray-valid detector; otherwise stray is tied low.
module wr_out_buffer #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 16
) (
    input logic            clk,
    input logic            rst,
    wr_out_buffer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [31:0]       fifo [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] addr;
    logic              pclr;

    logic full;
    logic empty;
    logic ready;
    logic push;
    logic we;
    logic pop;
    logic final_word;
    logic begin_tile;

    always_comb begin
        full       = (occ == OCC_W'(DEPTH));
        empty      = (occ == '0);
        ready      = (state == RUN) && !full;
        // The packer's valid is stale while its clear pulse is in flight.
        push       = bus.in_valid && ready && !pclr;
        we         = ((state == RUN) || (state == FLUSH)) && !empty;
        pop        = we && bus.mem_gnt;
        final_word = bus.in_last || (word_cnt >= CNT_W'(NUM_WORDS - 1));
        begin_tile = bus.start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) state <= RUN;
                RUN:        if (push && final_word) state <= FLUSH;
                // Enter DONE on the edge that pops the final word.
                FLUSH:      if (empty || ((occ == OCC_W'(1)) && pop)) state <= DONE;
                default:    state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            word_cnt <= '0;
            addr     <= BASE_ADDR;
            pclr     <= 1'b0;
        end else begin
            pclr <= push;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (begin_tile) begin
                word_cnt <= '0;
                addr     <= BASE_ADDR;
            end else begin
                if (push && (word_cnt != CNT_W'(NUM_WORDS))) word_cnt <= word_cnt + CNT_W'(1);
                if (pop) addr <= addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.in_word;
    end

`ifdef WROB_STRAY_FLAG_EN
    logic stray_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stray_q <= 1'b0;
        end else if (begin_tile) begin
            stray_q <= 1'b0;
        end else if (bus.in_valid && !pclr && (state != RUN)) begin
            stray_q <= 1'b1;
        end
    end

    assign bus.stray = stray_q;
`else
    assign bus.stray = 1'b0;
`endif

    assign bus.in_ready  = ready;
    assign bus.pack_clr  = pclr;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = fifo[rd_ptr];
    assign bus.mem_we    = we;
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_wr_out_buffer.sv
// Self-checking bench for wr_out_buffer: two instances (wide address / narrow wrapping address)
// share one packer+memory stimulus; a reference queue of expected writes is built per tile.
module tb_wr_out_buffer;
    localparam int        A_W     = 10;
    localparam logic [9:0] A_BASE = 10'h010;
    localparam int        A_NW    = 16;
    localparam int        A_DEPTH = 4;
    localparam int        B_W     = 4;
    localparam logic [3:0] B_BASE = 4'hE;
    localparam int        B_NW    = 3;
`ifdef WROB_STRAY_FLAG_EN
    localparam logic STRAY_EN = 1'b1;
`else
    localparam logic STRAY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_last, mem_gnt;
    logic [31:0] in_word;
    logic        sel;
    int          errors = 0;
    int          checks = 0;

    wr_out_buffer_if #(.ADDR_W(A_W)) ifa ();
    wr_out_buffer_if #(.ADDR_W(B_W)) ifb ();

    assign ifa.start = start;  assign ifb.start = start;
    assign ifa.in_word = in_word;  assign ifb.in_word = in_word;
    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_last = in_last;  assign ifb.in_last = in_last;
    assign ifa.mem_gnt = mem_gnt;  assign ifb.mem_gnt = mem_gnt;

    wr_out_buffer #(.DEPTH(A_DEPTH), .ADDR_W(A_W), .BASE_ADDR(A_BASE), .NUM_WORDS(A_NW))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    wr_out_buffer #(.DEPTH(4), .ADDR_W(B_W), .BASE_ADDR(B_BASE), .NUM_WORDS(B_NW))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    logic        o_ready, o_pclr, o_we, o_done, o_stray;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;

    always_comb begin
        if (sel) begin
            o_ready = ifb.in_ready; o_pclr = ifb.pack_clr; o_we = ifb.mem_we;
            o_done = ifb.done; o_stray = ifb.stray; o_addr = {6'b0, ifb.mem_addr}; o_wdata = ifb.mem_wdata;
        end else begin
            o_ready = ifa.in_ready; o_pclr = ifa.pack_clr; o_we = ifa.mem_we;
            o_done = ifa.done; o_stray = ifa.stray; o_addr = ifa.mem_addr; o_wdata = ifa.mem_wdata;
        end
    end

    // Memory-side monitor: records completed writes and pack_clr pulses of the selected instance.
    logic [41:0] obs_q[$];
    int          pclr_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (o_we === 1'b1 && mem_gnt === 1'b1) begin
                obs_q.push_back({o_addr, o_wdata});
                last_wr_cyc = cyc;
            end
            if (o_pclr === 1'b1) pclr_cnt++;
        end
    end

    // Packer model and reference state.
    logic [31:0] words[$];
    logic [41:0] exp_q[$];
    int          last_pos;
    int          widx;
    bit          adv;
    int          obs_base;
    int          pclr_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_gnt = 1'b0; in_word = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic present();
        if (widx < words.size()) begin
            in_valid = 1'b1; in_word = words[widx]; in_last = (widx == last_pos);
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic start_tile();
        obs_base = obs_q.size(); pclr_base = pclr_cnt;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; widx = 0; adv = 1'b0;
        present();
    endtask

    // Packer holds valid through its clear cycle and presents the next word after it.
    task automatic run_cycles(input int budget, input int pct);
        for (int c = 0; c < budget; c++) begin
            if (o_done === 1'b1) break;
            mem_gnt = ($urandom_range(99) < pct);
            tick();
            if (adv) begin
                adv = 1'b0;
                present();
            end else if (o_pclr === 1'b1) begin
                widx++;
                adv = 1'b1;
            end
        end
    endtask

    // Expected writes: accepted words up to last flag or NUM_WORDS, at BASE+k modulo 2^width.
    task automatic build_exp(input int n, input int nw, input int base, input int wbits);
        int nacc;
        nacc = (last_pos >= 0 && last_pos < n) ? last_pos + 1 : n;
        if (nacc > nw) nacc = nw;
        exp_q.delete();
        for (int k = 0; k < nacc; k++)
            exp_q.push_back({10'((base + k) % (1 << wbits)), words[k]});
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_gnt = 1'b1; in_word = '0;
        tick();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", o_we); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++; if (o_pclr !== 1'b0) begin errors++; $display("FAIL reset_pclr: got %b want 0", o_pclr); end
        checks++; if (o_stray !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b want 0", o_stray); end
        checks++; if (o_addr !== A_BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", o_addr, A_BASE); end
        checks++; if (ifb.mem_addr !== B_BASE) begin errors++; $display("FAIL reset_addr_b: got %h want %h", ifb.mem_addr, B_BASE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_tile();
        do_reset();
        sel = 1'b0;
        words = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        last_pos = 2;
        build_exp(3, A_NW, int'(A_BASE), A_W);
        start_tile();
        run_cycles(60, 100);
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_base + k >= obs_q.size() || obs_q[obs_base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL basic_write%0d: got %h want %h", k,
                         (obs_base + k < obs_q.size()) ? obs_q[obs_base + k] : 42'h0, exp_q[k]);
            end
        end
        checks++; if (pclr_cnt - pclr_base != 3) begin errors++; $display("FAIL basic_pclr: got %0d want 3", pclr_cnt - pclr_base); end
        checks++;
        if (o_done !== 1'b1 || cyc != last_wr_cyc + 1) begin
            errors++; $display("FAIL basic_done: got done=%b at cyc %0d want 1 at %0d", o_done, cyc, last_wr_cyc + 1);
        end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", o_ready); end
        tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL basic_done_level: got %b want 1", o_done); end
    endtask

    task automatic test_backpressure();
        do_reset();
        sel = 1'b0;
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        last_pos = 4;
        build_exp(5, A_NW, int'(A_BASE), A_W);
        start_tile();
        run_cycles(12, 0);
        checks++; if (pclr_cnt - pclr_base != A_DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", pclr_cnt - pclr_base, A_DEPTH); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", o_ready); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL bp_we: got %b want 1", o_we); end
        checks++; if (o_addr !== A_BASE || o_wdata !== words[0]) begin errors++; $display("FAIL bp_hold1: got %h/%h want %h/%h", o_addr, o_wdata, A_BASE, words[0]); end
        run_cycles(5, 0);
        checks++; if (o_addr !== A_BASE || o_wdata !== words[0]) begin errors++; $display("FAIL bp_hold2: got %h/%h want %h/%h", o_addr, o_wdata, A_BASE, words[0]); end
        checks++; if (pclr_cnt - pclr_base != A_DEPTH) begin errors++; $display("FAIL bp_accepts2: got %0d want %0d", pclr_cnt - pclr_base, A_DEPTH); end
        run_cycles(60, 100);
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_base + k >= obs_q.size() || obs_q[obs_base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_write%0d: got %h want %h", k,
                         (obs_base + k < obs_q.size()) ? obs_q[obs_base + k] : 42'h0, exp_q[k]);
            end
        end
        checks++;
        if (o_done !== 1'b1 || cyc != last_wr_cyc + 1) begin
            errors++; $display("FAIL bp_done: got done=%b at cyc %0d want 1 at %0d", o_done, cyc, last_wr_cyc + 1);
        end
    endtask

    task automatic test_random_tiles();
        do_reset();
        sel = 1'b0;
        for (int t = 0; t < 6; t++) begin
            int n;
            int pct;
            n = int'($urandom_range(8, 1));
            pct = int'($urandom_range(100, 30));
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            last_pos = n - 1;
            build_exp(n, A_NW, int'(A_BASE), A_W);
            start_tile();
            run_cycles(300, pct);
            checks++;
            if (obs_q.size() - obs_base != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, obs_q.size() - obs_base, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_base + k >= obs_q.size() || obs_q[obs_base + k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got %h want %h", t, k,
                             (obs_base + k < obs_q.size()) ? obs_q[obs_base + k] : 42'h0, exp_q[k]);
                end
            end
            checks++;
            if (o_done !== 1'b1 || cyc != last_wr_cyc + 1) begin
                errors++; $display("FAIL rand%0d_done: got done=%b at cyc %0d want 1 at %0d", t, o_done, cyc, last_wr_cyc + 1);
            end
        end
    endtask

    task automatic test_implicit_wrap();
        do_reset();
        sel = 1'b1;
        words = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
        last_pos = -1;
        build_exp(4, B_NW, int'(B_BASE), B_W);
        start_tile();
        run_cycles(60, 100);
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_base + k >= obs_q.size() || obs_q[obs_base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wrap_write%0d: got %h want %h", k,
                         (obs_base + k < obs_q.size()) ? obs_q[obs_base + k] : 42'h0, exp_q[k]);
            end
        end
        checks++; if (pclr_cnt - pclr_base != B_NW) begin errors++; $display("FAIL implicit_accepts: got %0d want %0d", pclr_cnt - pclr_base, B_NW); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL implicit_ready: got %b want 0", o_ready); end
        checks++;
        if (o_done !== 1'b1 || cyc != last_wr_cyc + 1) begin
            errors++; $display("FAIL implicit_done: got done=%b at cyc %0d want 1 at %0d", o_done, cyc, last_wr_cyc + 1);
        end
        in_valid = 1'b0;
        tick();
        // A fresh tile from DONE restarts the address at BASE.
        words = '{32'h12345678, 32'h9ABCDEF0};
        last_pos = 1;
        build_exp(2, B_NW, int'(B_BASE), B_W);
        start_tile();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL restart_done: got %b want 0", o_done); end
        run_cycles(60, 100);
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL restart_count: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_base + k >= obs_q.size() || obs_q[obs_base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL restart_write%0d: got %h want %h", k,
                         (obs_base + k < obs_q.size()) ? obs_q[obs_base + k] : 42'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        int base;
        do_reset();
        sel = 1'b0;
        words = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        last_pos = 2;
        start_tile();
        for (int c = 0; c < 20; c++) begin
            if (pclr_cnt - pclr_base >= 2) break;
            run_cycles(1, 0);
        end
        checks++; if (pclr_cnt - pclr_base != 2) begin errors++; $display("FAIL midrst_fill: got %0d want 2", pclr_cnt - pclr_base); end
        rst = 1'b1;
        #1;
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b want 0", o_we); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", o_ready); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", o_done); end
        checks++; if (o_addr !== A_BASE) begin errors++; $display("FAIL midrst_addr: got %h want %h", o_addr, A_BASE); end
        tick();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_gnt = 1'b1;
        base = obs_q.size();
        repeat (8) tick();
        checks++; if (obs_q.size() != base) begin errors++; $display("FAIL midrst_nowrite: got %0d writes want 0", obs_q.size() - base); end
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL midrst_we_after: got %b want 0", o_we); end
    endtask

    task automatic test_stray();
        do_reset();
        sel = 1'b0;
        in_valid = 1'b1; in_word = 32'hFFFF0000;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (o_stray !== STRAY_EN) begin errors++; $display("FAIL stray_set: got %b want %b", o_stray, STRAY_EN); end
        repeat (3) tick();
        checks++; if (o_stray !== STRAY_EN) begin errors++; $display("FAIL stray_hold: got %b want %b", o_stray, STRAY_EN); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (o_stray !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", o_stray); end
        do_reset();
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic_tile();
        test_backpressure();
        test_random_tiles();
        test_implicit_wrap();
        test_reset_mid_tile();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
